audio_tone_arbiter: RTL and testbench

AUDIO_TONE_ARBITER -- requirements
Module: audio_tone_arbiter

---
 rtl/audio_tone_arbiter.sv | 142 ++++++++++++++
 tb/tb_audio_tone_arbiter.sv | 314 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/audio_tone_arbiter.sv
// Four-requester square-wave tone arbiter feeding an audio controller FIFO.
// Higher index preempts, lower index queues as sticky pending requests.
module audio_tone_arbiter #(
   parameter logic [31:0] AMPLITUDE = 32'd10000000,
   parameter logic [18:0] HP0 = 19'd63775,
   parameter logic [18:0] HP1 = 19'd47800,
   parameter logic [18:0] HP2 = 19'd42560,
   parameter logic [18:0] HP3 = 19'd31887,
   parameter logic [25:0] DUR0 = 26'd25000000,
   parameter logic [25:0] DUR1 = 26'd12500000,
   parameter logic [25:0] DUR2 = 26'd5000000,
   parameter logic [25:0] DUR3 = 26'd50000000
) (
   input  logic        CLOCK_50,
   input  logic        reset,
   input  logic [3:0]  req,
   input  logic        mute,
   input  logic        audio_out_allowed,
   output logic [31:0] left_channel_audio_out,
   output logic [31:0] right_channel_audio_out,
   output logic        write_audio_out,
   output logic        busy,
   output logic [1:0]  active_id,
   output logic [3:0]  done
);

   typedef enum logic {IDLE, PLAY} state_t;

   state_t      state, state_n;
   logic [3:0]  pending, pending_n;
   logic [1:0]  id_n;
   logic [18:0] tone_cnt, tone_n;
   logic [25:0] dur_cnt, dur_n;
   logic        snd, snd_n;

   logic [3:0]  any, hi_req, id_bit, win_bit;
   logic [1:0]  win;
   logic [18:0] hp_cur;

   function automatic logic [25:0] dur_of(input logic [1:0] i);
      unique case (i)
         2'd0: dur_of = DUR0;
         2'd1: dur_of = DUR1;
         2'd2: dur_of = DUR2;
         default: dur_of = DUR3;
      endcase
   endfunction

   always_comb begin
      unique case (active_id)
         2'd0: hp_cur = HP0;
         2'd1: hp_cur = HP1;
         2'd2: hp_cur = HP2;
         default: hp_cur = HP3;
      endcase
   end

   assign any     = pending | req;
   assign id_bit  = 4'b0001 << active_id;
   assign hi_req  = req & (4'b1110 << active_id);
   assign win_bit = 4'b0001 << win;

   // Pending bits always sit below the active index, so the highest bit
   // of (pending | req) is also the preemption winner during PLAY.
   always_comb begin
      if (any[3])      win = 2'd3;
      else if (any[2]) win = 2'd2;
      else if (any[1]) win = 2'd1;
      else             win = 2'd0;
   end

   always_comb begin
      state_n   = state;
      pending_n = pending;
      id_n      = active_id;
      tone_n    = tone_cnt;
      dur_n     = dur_cnt;
      snd_n     = snd;
      done      = 4'b0000;
      unique case (state)
         IDLE: begin
            if (|any) begin
               state_n   = PLAY;
               id_n      = win;
               tone_n    = '0;
               snd_n     = 1'b0;
               dur_n     = dur_of(win) - 26'd1;
               pending_n = any & ~win_bit;
            end
         end
         PLAY: begin
            if (tone_cnt == hp_cur) begin
               tone_n = '0;
               snd_n  = ~snd;
            end else begin
               tone_n = tone_cnt + 19'd1;
            end
            dur_n     = dur_cnt - 26'd1;
            pending_n = pending | (req & ~id_bit);
            if (|hi_req) begin
               id_n      = win;
               tone_n    = '0;
               snd_n     = 1'b0;
               dur_n     = dur_of(win) - 26'd1;
               pending_n = any & ~win_bit & ~id_bit;
            end else if (req[active_id]) begin
               dur_n = dur_of(active_id) - 26'd1;
            end else if (dur_cnt == 26'd0) begin
               done    = id_bit;
               state_n = IDLE;
            end
         end
         default: state_n = IDLE;
      endcase
      if (reset) done = 4'b0000;
   end

   always_ff @(posedge CLOCK_50) begin
      if (reset) begin
         state     <= IDLE;
         pending   <= '0;
         active_id <= '0;
         tone_cnt  <= '0;
         dur_cnt   <= '0;
         snd       <= 1'b0;
      end else begin
         state     <= state_n;
         pending   <= pending_n;
         active_id <= id_n;
         tone_cnt  <= tone_n;
         dur_cnt   <= dur_n;
         snd       <= snd_n;
      end
   end

   assign busy = (state == PLAY);
   assign left_channel_audio_out = (busy && !mute) ?
      (snd ? AMPLITUDE : -AMPLITUDE) : 32'd0;
   assign right_channel_audio_out = left_channel_audio_out;
   assign write_audio_out = audio_out_allowed;

endmodule

// File: tb/tb_audio_tone_arbiter.sv
// Testbench for audio_tone_arbiter: directed scenarios plus random
// traffic checked against a cycle-level behavioural model.
module tb_audio_tone_arbiter;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [3:0]  req = 4'b0000;
   logic        mute = 1'b0;
   logic        audio_out_allowed = 1'b1;
   logic [31:0] left, right;
   logic        write, busy;
   logic [1:0]  active_id;
   logic [3:0]  done;

   int passed = 0;
   int total = 0;

   localparam logic [31:0] PA = 32'd10000000;
   localparam logic [31:0] NA = -PA;

   int hpv[4] = '{1, 2, 3, 0};
   int durv[4] = '{8, 6, 5, 4};
   logic [31:0] lv[8] = '{NA, NA, PA, PA, NA, NA, PA, PA};

   audio_tone_arbiter #(
      .HP0(19'd1), .HP1(19'd2), .HP2(19'd3), .HP3(19'd0),
      .DUR0(26'd8), .DUR1(26'd6), .DUR2(26'd5), .DUR3(26'd4)
   ) dut (
      .CLOCK_50(clk),
      .reset(reset),
      .req(req),
      .mute(mute),
      .audio_out_allowed(audio_out_allowed),
      .left_channel_audio_out(left),
      .right_channel_audio_out(right),
      .write_audio_out(write),
      .busy(busy),
      .active_id(active_id),
      .done(done)
   );

   always #5 clk = ~clk;

   // Model: age = cycles since grant, rem = cycles left including this one.
   bit         m_play = 0;
   int         m_id = 0;
   int         m_age = 0;
   int         m_rem = 0;
   logic [3:0] m_pend = 4'b0000;

   logic        e_busy, e_wr;
   logic [31:0] e_smp;
   logic [3:0]  e_done;
   logic [1:0]  e_id;

   function automatic int top_bit(input logic [3:0] v);
      int r = -1;
      for (int i = 0; i < 4; i++) if (v[i]) r = i;
      return r;
   endfunction

   function automatic bit higher_req(input logic [3:0] r, input int id);
      bit h = 0;
      for (int i = 0; i < 4; i++) if (i > id && r[i]) h = 1;
      return h;
   endfunction

   always @(posedge clk) begin
      int w;
      logic [3:0] any;
      if (reset) begin
         m_play = 0;
         m_pend = 4'b0000;
         m_id = 0;
      end else if (!m_play) begin
         any = m_pend | req;
         if (any != 4'b0000) begin
            w = top_bit(any);
            m_pend = any & ~(4'b0001 << w);
            m_play = 1; m_id = w; m_age = 0; m_rem = durv[w];
         end
      end else if (higher_req(req, m_id)) begin
         w = top_bit(req);
         m_pend = (m_pend | req) & ~(4'b0001 << w) & ~(4'b0001 << m_id);
         m_play = 1; m_id = w; m_age = 0; m_rem = durv[w];
      end else begin
         m_pend = m_pend | (req & ~(4'b0001 << m_id));
         if (req[m_id]) begin
            m_rem = durv[m_id];
            m_age++;
         end else if (m_rem == 1) begin
            m_play = 0;
         end else begin
            m_rem--;
            m_age++;
         end
      end
   end

   task automatic cyc(input logic [3:0] r, input logic mu, al, rs);
      @(negedge clk);
      req = r; mute = mu; audio_out_allowed = al; reset = rs;
      #1;
      e_busy = m_play;
      e_id = m_id[1:0];
      e_wr = al;
      e_smp = 32'd0;
      if (m_play && !mu)
         e_smp = (((m_age / (hpv[m_id] + 1)) % 2) == 1) ? PA : NA;
      e_done = 4'b0000;
      if (m_play && !rs && m_rem == 1 && !higher_req(r, m_id) && !r[m_id])
         e_done = 4'b0001 << m_id;
   endtask

   task automatic test_reset();
      cyc(4'b1111, 0, 1, 1);
      cyc(4'b0000, 0, 1, 1);
      cyc(4'b0000, 0, 1, 0);
      total++;
      if (busy !== 1'b0) $display("FAIL reset_busy got %b want 0", busy);
      else passed++;
      total++;
      if (done !== 4'b0000) $display("FAIL reset_done got %b want 0000", done);
      else passed++;
      total++;
      if (left !== 32'd0) $display("FAIL reset_left got %0h want 0", left);
      else passed++;
      cyc(4'b0000, 0, 0, 0);
      total++;
      if (write !== 1'b0) $display("FAIL reset_write got %b want 0", write);
      else passed++;
   endtask

   task automatic test_basic();
      cyc(4'b0001, 0, 1, 0);
      total++;
      if (busy !== 1'b0) $display("FAIL basic_idle got %b want 0", busy);
      else passed++;
      for (int k = 1; k <= 8; k++) begin
         cyc(4'b0000, 0, 1, 0);
         total++;
         if (busy !== 1'b1 || active_id !== 2'd0)
            $display("FAIL basic_busy k=%0d got %b/%0d want 1/0", k, busy, active_id);
         else passed++;
         total++;
         if (left !== lv[k-1] || right !== lv[k-1])
            $display("FAIL basic_sample k=%0d got %0h want %0h", k, left, lv[k-1]);
         else passed++;
         total++;
         if (done !== ((k == 8) ? 4'b0001 : 4'b0000))
            $display("FAIL basic_done k=%0d got %b", k, done);
         else passed++;
      end
      cyc(4'b0000, 0, 1, 0);
      total++;
      if (busy !== 1'b0) $display("FAIL basic_end got %b want 0", busy);
      else passed++;
   endtask

   task automatic test_preempt();
      cyc(4'b0001, 0, 1, 0);
      for (int k = 0; k < 3; k++) cyc(4'b0000, 0, 1, 0);
      cyc(4'b0010, 0, 1, 0);
      total++;
      if (done !== 4'b0000) $display("FAIL preempt_nodone got %b want 0000", done);
      else passed++;
      for (int k = 1; k <= 6; k++) begin
         cyc(4'b0000, 0, 1, 0);
         total++;
         if (busy !== 1'b1 || active_id !== 2'd1)
            $display("FAIL preempt_id k=%0d got %b/%0d want 1/1", k, busy, active_id);
         else passed++;
         total++;
         if (done !== ((k == 6) ? 4'b0010 : 4'b0000))
            $display("FAIL preempt_done k=%0d got %b", k, done);
         else passed++;
      end
      cyc(4'b0000, 0, 1, 0);
   endtask

   task automatic test_pending();
      cyc(4'b1000, 0, 1, 0);
      cyc(4'b0001, 0, 1, 0);
      total++;
      if (active_id !== 2'd3 || done !== 4'b0000)
         $display("FAIL pend_keep got %0d/%b want 3/0000", active_id, done);
      else passed++;
      for (int k = 2; k <= 4; k++) begin
         cyc(4'b0000, 0, 1, 0);
         total++;
         if (done !== ((k == 4) ? 4'b1000 : 4'b0000))
            $display("FAIL pend_done3 k=%0d got %b", k, done);
         else passed++;
      end
      cyc(4'b0000, 0, 1, 0);
      total++;
      if (busy !== 1'b0) $display("FAIL pend_idle got %b want 0", busy);
      else passed++;
      for (int k = 1; k <= 8; k++) begin
         cyc(4'b0000, 0, 1, 0);
         total++;
         if (busy !== 1'b1 || active_id !== 2'd0 ||
             done !== ((k == 8) ? 4'b0001 : 4'b0000))
            $display("FAIL pend_play0 k=%0d got %b/%0d/%b", k, busy, active_id, done);
         else passed++;
      end
      cyc(4'b0000, 0, 1, 0);
   endtask

   task automatic test_retrigger();
      int n;
      cyc(4'b0001, 0, 1, 0);
      for (int k = 1; k <= 5; k++) cyc(4'b0000, 0, 1, 0);
      cyc(4'b0001, 0, 1, 0);
      total++;
      if (done !== 4'b0000) $display("FAIL retrig_nodone got %b want 0000", done);
      else passed++;
      n = 1;
      while (n <= 20) begin
         cyc(4'b0000, 0, 1, 0);
         if (done !== 4'b0000) break;
         n++;
      end
      total++;
      if (n !== 8 || done !== 4'b0001)
         $display("FAIL retrig_delay got %0d/%b want 8/0001", n, done);
      else passed++;
      cyc(4'b0000, 0, 1, 0);
      total++;
      if (busy !== 1'b0) $display("FAIL retrig_end got %b want 0", busy);
      else passed++;
   endtask

   task automatic test_mute_fifo();
      cyc(4'b0001, 1, 1, 0);
      for (int k = 1; k <= 8; k++) begin
         cyc(4'b0000, 1, k[0], 0);
         total++;
         if (left !== 32'd0 || right !== 32'd0 || busy !== 1'b1)
            $display("FAIL mute_smp k=%0d got %0h/%b want 0/1", k, left, busy);
         else passed++;
         total++;
         if (write !== k[0] || done !== ((k == 8) ? 4'b0001 : 4'b0000))
            $display("FAIL mute_wr_done k=%0d got %b/%b", k, write, done);
         else passed++;
      end
      cyc(4'b0001, 0, 0, 0);
      for (int k = 1; k <= 8; k++) begin
         cyc(4'b0000, 0, 0, 0);
         total++;
         if (write !== 1'b0 || left !== lv[k-1])
            $display("FAIL nofifo k=%0d got %b/%0h want 0/%0h", k, write, left, lv[k-1]);
         else passed++;
      end
      cyc(4'b0000, 0, 1, 0);
   endtask

   task automatic test_reset_mid();
      cyc(4'b1000, 0, 1, 0);
      cyc(4'b0001, 0, 1, 0);
      cyc(4'b0000, 0, 1, 1);
      cyc(4'b0000, 0, 1, 0);
      total++;
      if (busy !== 1'b0 || done !== 4'b0000 || left !== 32'd0)
         $display("FAIL rstmid got %b/%b/%0h want 0/0000/0", busy, done, left);
      else passed++;
      for (int k = 0; k < 4; k++) begin
         cyc(4'b0000, 0, 1, 0);
         total++;
         if (busy !== 1'b0 || done !== 4'b0000)
            $display("FAIL rstmid_pend k=%0d got %b/%b want 0/0000", k, busy, done);
         else passed++;
      end
   endtask

   task automatic test_random();
      logic [3:0] r;
      for (int c = 0; c < 600; c++) begin
         for (int i = 0; i < 4; i++) r[i] = ($urandom_range(0, 9) == 0);
         cyc(r, ($urandom_range(0, 7) == 0), 1'($urandom_range(0, 1)),
             ($urandom_range(0, 99) == 0));
         total++;
         if (busy !== e_busy || left !== e_smp || right !== e_smp)
            $display("FAIL rnd_out c=%0d got %b/%0h/%0h want %b/%0h",
                     c, busy, left, right, e_busy, e_smp);
         else passed++;
         total++;
         if (done !== e_done || write !== e_wr)
            $display("FAIL rnd_done c=%0d got %b/%b want %b/%b",
                     c, done, write, e_done, e_wr);
         else passed++;
         if (e_busy) begin
            total++;
            if (active_id !== e_id)
               $display("FAIL rnd_id c=%0d got %0d want %0d", c, active_id, e_id);
            else passed++;
         end
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_preempt();
      test_pending();
      test_retrigger();
      test_mute_fifo();
      test_reset_mid();
      test_random();
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
